// File: rtl/prio_encoder_capture.sv
// rtl/prio_encoder_capture.sv - sticky event capture with prioritised valid/ready index hand-off
module prio_encoder_capture #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         msb_first,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         ovf,
    input  logic         clr_ovf
);

    logic         take;
    logic         load;
    logic [N-1:0] clr_mask;
    logic [N-1:0] set_mask;
    logic [N-1:0] sel;
    logic [W-1:0] sel_idx;

    function automatic logic [W-1:0] encode(input logic [N-1:0] v, input logic msb);
        logic [W-1:0] r;
        r = '0;
        if (msb) begin
            for (int i = 0; i < N; i++) begin
                if (v[i]) r = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (v[i]) r = W'(i);
            end
        end
        return r;
    endfunction

    always_comb begin
        take     = out_valid & out_ready;
        load     = !out_valid | take;
        clr_mask = take ? ({{(N-1){1'b0}}, 1'b1} << out_idx) : '0;
        set_mask = en ? req : '0;
        // Selection looks only at already-registered pending; new pulses wait one cycle.
        sel      = pending & ~clr_mask;
        sel_idx  = encode(sel, msb_first);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            if (|(set_mask & pending & ~clr_mask)) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
            if (load) begin
                out_valid <= |sel;
                out_idx   <= sel_idx;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_capture.sv
// tb/tb_prio_encoder_capture.sv - directed self-checking bench for prio_encoder_capture
module tb_prio_encoder_capture;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       msb_first;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       ovf;
    logic       clr_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    prio_encoder_capture #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .msb_first (msb_first),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; req = '0; msb_first = 1'b1; out_ready = 1'b1; clr_ovf = 1'b0;
        #12;
        chk("rst_pending", pending, 8'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_idx", out_idx, 3'd0);
        chk("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        step();

        // MSB-first drain
        msb_first = 1'b1; req = 8'hA0;
        step(); req = '0;
        chk("msb_e0_pending", pending, 8'hA0);
        chk("msb_e0_valid", out_valid, 1'b0);
        step();
        chk("msb_e1_valid", out_valid, 1'b1);
        chk("msb_e1_idx", out_idx, 3'd7);
        step();
        chk("msb_e2_valid", out_valid, 1'b1);
        chk("msb_e2_idx", out_idx, 3'd5);
        chk("msb_e2_pending", pending, 8'h20);
        step();
        chk("msb_e3_valid", out_valid, 1'b0);
        chk("msb_e3_pending", pending, 8'h00);

        // LSB-first drain
        msb_first = 1'b0; req = 8'hA0;
        step(); req = '0;
        step();
        chk("lsb_e1_idx", out_idx, 3'd5);
        chk("lsb_e1_valid", out_valid, 1'b1);
        step();
        chk("lsb_e2_idx", out_idx, 3'd7);
        step();
        chk("lsb_e3_valid", out_valid, 1'b0);
        chk("lsb_e3_pending", pending, 8'h00);

        // Backpressure hold
        out_ready = 1'b0; msb_first = 1'b1; req = 8'h09;
        step(); req = '0;
        step();
        chk("bp_idx", out_idx, 3'd3);
        chk("bp_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            msb_first = ~msb_first;
            step();
            chk($sformatf("bp_hold_idx_%0d", i), out_idx, 3'd3);
            chk($sformatf("bp_hold_valid_%0d", i), out_valid, 1'b1);
        end
        chk("bp_pending", pending, 8'h09);
        out_ready = 1'b1;
        step();
        chk("bp_next_idx", out_idx, 3'd0);
        chk("bp_next_valid", out_valid, 1'b1);
        chk("bp_next_pending", pending, 8'h01);
        step();
        chk("bp_done_valid", out_valid, 1'b0);
        chk("bp_done_pending", pending, 8'h00);

        // Overflow and set/clear race
        out_ready = 1'b0; msb_first = 1'b1; req = 8'h0C;
        step(); req = '0;
        step();
        chk("ovf_pres_idx", out_idx, 3'd3);
        chk("ovf_pre", ovf, 1'b0);
        req = 8'h04;
        step(); req = '0;
        chk("ovf_set", ovf, 1'b1);
        clr_ovf = 1'b1;
        step(); clr_ovf = 1'b0;
        chk("ovf_clr", ovf, 1'b0);
        out_ready = 1'b1;
        step();
        chk("race_pres_idx", out_idx, 3'd2);
        chk("race_pres_valid", out_valid, 1'b1);
        req = 8'h04;
        step(); req = '0;
        chk("race_ovf", ovf, 1'b0);
        chk("race_pending", pending, 8'h04);
        chk("race_valid_gap", out_valid, 1'b0);
        step();
        chk("race_repres_valid", out_valid, 1'b1);
        chk("race_repres_idx", out_idx, 3'd2);
        step();
        chk("race_done_valid", out_valid, 1'b0);
        chk("race_done_pending", pending, 8'h00);

        // Enable gating
        en = 1'b0; req = 8'hFF;
        step(); step(); step();
        req = '0;
        chk("en0_pending", pending, 8'h00);
        chk("en0_valid", out_valid, 1'b0);
        en = 1'b1; req = 8'h01;
        step(); req = '0;
        chk("en1_e0_valid", out_valid, 1'b0);
        chk("en1_e0_pending", pending, 8'h01);
        step();
        chk("en1_e1_valid", out_valid, 1'b1);
        chk("en1_e1_idx", out_idx, 3'd0);
        step();

        // Asynchronous reset mid-operation
        out_ready = 1'b0; msb_first = 1'b1; req = 8'hFF;
        step();
        step();
        req = '0;
        chk("mid_pending", pending, 8'hFF);
        chk("mid_valid", out_valid, 1'b1);
        chk("mid_idx", out_idx, 3'd7);
        chk("mid_ovf", ovf, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pending", pending, 8'h00);
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_idx", out_idx, 3'd0);
        chk("arst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_encoder_capture.md
Name: prio_encoder_capture

Overview:
- Parametrised, registered successor to the 8:3 encoder. Captures single-cycle event pulses on N request lines into a sticky pending register.
- Presents the pending requests one at a time, as a binary index, over a valid/ready output handshake.
- Priority direction is selectable per hand-off. Each bit is cleared when its index is accepted.
- Sits between event sources (interrupt/status pulses) and a single consumer that services one index at a time.

Parameters:
- N, 8, number of request lines; legal range 2..64.
- W, $clog2(N), index width; fixed by N, not overridden.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, capture enable; 0 = req ignored, pending still drains.
- req, input, N, event pulses; bit i set = event on line i.
- msb_first, input, 1, 1 = highest set index wins; 0 = lowest set index wins.
- out_idx, output, W, index of presented request.
- out_valid, output, 1, out_idx valid.
- out_ready, input, 1, consumer accepts out_idx when out_valid & out_ready.
- pending, output, N, current pending register.
- ovf, output, 1, sticky: an event arrived on a line already pending.
- clr_ovf, input, 1, synchronous clear of ovf.

Behaviour:
- Reset (async, rst_n=0): pending=0, out_valid=0, out_idx=0, ovf=0. Reset mid-drain discards all pending and presented requests.
- Definitions:
  - take = out_valid & out_ready.
  - clr_mask = one-hot(out_idx) if take, else 0.
  - set_mask = req if en, else 0.
- Pending update: pending <= (pending & ~clr_mask) | set_mask. Set wins over clear on the same bit in the same cycle.
- Overflow: ovf <= 1 if any bit of set_mask & pending & ~clr_mask is 1. Otherwise, if clr_ovf=1, ovf <= 0. Set wins over clr_ovf.
- Output register loads when (!out_valid | take):
  - sel = pending & ~clr_mask. This uses the registered pending only, not this cycle's set_mask.
  - out_valid <= |sel.
  - out_idx <= priority_encode(sel, msb_first); out_idx <= 0 when sel=0.
- Output holds when out_valid & !out_ready: out_idx and out_valid stay stable. Changes on msb_first or new req do not affect the held value.
- msb_first is sampled only at the load edge.
- Latency: req pulse sampled at edge k enters pending at edge k. With an idle output, out_valid=1 with that index after edge k+1. Minimum 2 cycles from req asserted to valid.
- Throughput: one index per cycle while out_ready=1 and pending is non-empty.
- Presented bit stays set in pending until its take edge. It is never presented twice without a re-request.
- Re-request of a bit in its take cycle: the bit stays pending. It is not selected on that load (masked by clr_mask) and is presented on a later load. It does not set ovf.
- en=0: no capture. Drain and handshake continue unaffected.
- out_idx is always < N. Bits of sel above N-1 do not exist.

Test Plan:
- Reset: assert rst_n=0 mid-operation with pending=0xFF and out_valid=1 -> pending=0x00, out_valid=0, out_idx=0, ovf=0 immediately, without a clock edge.
- MSB drain: msb_first=1, out_ready=1, req=0xA0 for one cycle (edge 0) -> out_idx=7, valid after edge 1; out_idx=5 after edge 2; out_valid=0 and pending=0x00 after edge 3.
- LSB drain: same stimulus with msb_first=0 -> out_idx=5 then 7, then out_valid=0.
- Backpressure: out_ready=0, msb_first=1, req=0x09 one cycle -> out_idx=3, out_valid=1, held stable for 5 cycles; toggle msb_first during hold with no change. pending=0x09. Raise out_ready -> 3 accepted, then 0 presented and accepted, pending=0x00.
- Overflow and set/clear race:
  - With bit 2 pending and not presented, pulse req=0x04 -> ovf=1.
  - Pulse clr_ovf -> ovf=0.
  - Pulse req=0x04 in the same cycle that idx 2 is taken -> ovf stays 0, pending[2]=1, idx 2 presented again on a later load.
- Enable gating: en=0, req=0xFF for 3 cycles -> pending=0x00, out_valid=0. Then en=1 with req=0x01 -> out_idx=0 valid 2 cycles later.
